// File: rtl/pcore_interface_defs.sv
// Types and constants shared across the fetch/decode boundary of the core.
package pcore_interface_defs;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            is_c;
  } type_aligner2id_s;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    logic [31:0]     data;
  } type_fetchword_s;

endpackage

// File: rtl/instr_aligner.sv
// Turns a stream of word-aligned fetch words into whole RV32IC instructions,
// stitching 32-bit instructions that straddle a word boundary.
module instr_aligner
  import pcore_interface_defs::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            word_valid_i,
  input  logic [XLEN-1:0] word_addr_i,
  input  logic [31:0]     word_data_i,
  output logic            word_ready_o,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_is_c_o,
  input  logic            instr_ready_i
);

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

  logic [15:0]     hw_q [4];
  logic [15:0]     hw_d [4];
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [XLEN-1:0] exp_addr_q, exp_addr_d;
  logic            drop_lo_q, drop_lo_d;

  logic            head_is_c;
  logic            out_valid;
  logic            pop;
  logic [2:0]      pop_len;
  logic            push_ok;
  logic [2:0]      push_len;
  logic [2:0]      base;
  logic [15:0]     push_hw [2];
  logic [95:0]     ext;
  logic [15:0]     shifted [4];
  type_aligner2id_s out_s;

  assign head_is_c    = is_compressed(hw_q[0]);
  assign out_valid    = (cnt_q >= 3'd1 && head_is_c) || (cnt_q >= 3'd2);
  assign pop          = out_valid && instr_ready_i;
  assign pop_len      = !pop ? 3'd0 : (head_is_c ? 3'd1 : 3'd2);

  // Space is judged before this cycle's pop so ready never depends on instr_ready_i.
  assign word_ready_o = (cnt_q <= 3'd2) && !redirect_i;
  assign push_ok      = word_valid_i && word_ready_o && (word_addr_i == exp_addr_q);
  assign push_len     = !push_ok ? 3'd0 : (drop_lo_q ? 3'd1 : 3'd2);
  assign push_hw[0]   = drop_lo_q ? word_data_i[31:16] : word_data_i[15:0];
  assign push_hw[1]   = word_data_i[31:16];
  assign base         = cnt_q - pop_len;

  // Zero padding lets the shift read past hw[3] without range special cases.
  assign ext = {32'h0, hw_q[3], hw_q[2], hw_q[1], hw_q[0]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign shifted[gi] = ext[{3'(gi) + pop_len, 4'b0000} +: 16];
    assign hw_d[gi] = (push_len != 3'd0 && 3'(gi) == base)          ? push_hw[0] :
                      (push_len == 3'd2 && 3'(gi) == base + 3'd1)   ? push_hw[1] :
                                                                      shifted[gi];
  end

  always_comb begin
    cnt_d      = cnt_q - pop_len + push_len;
    head_pc_d  = head_pc_q + XLEN'({pop_len, 1'b0});
    exp_addr_d = push_ok ? exp_addr_q + XLEN'(4) : exp_addr_q;
    drop_lo_d  = push_ok ? 1'b0 : drop_lo_q;
    if (redirect_i) begin
      cnt_d      = 3'd0;
      head_pc_d  = redirect_pc_i;
      exp_addr_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      drop_lo_d  = redirect_pc_i[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hw_q[i] <= 16'h0;
      cnt_q      <= 3'd0;
      head_pc_q  <= RESET_PC;
      exp_addr_q <= RESET_PC;
      drop_lo_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) hw_q[i] <= hw_d[i];
      cnt_q      <= cnt_d;
      head_pc_q  <= head_pc_d;
      exp_addr_q <= exp_addr_d;
      drop_lo_q  <= drop_lo_d;
    end
  end

  always_comb begin
    out_s       = '0;
    out_s.valid = out_valid;
    out_s.instr = !out_valid ? 32'h0 :
                  head_is_c  ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};
    out_s.pc    = head_pc_q;
    out_s.is_c  = out_valid && head_is_c;
  end

  assign instr_valid_o = out_s.valid;
  assign instr_o       = out_s.instr;
  assign instr_pc_o    = out_s.pc;
  assign instr_is_c_o  = out_s.is_c;

  a_cnt_max : assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= 3'd4);
  a_pop_le_cnt : assert property (@(posedge clk) disable iff (!rst_n) pop_len <= cnt_q);
  a_word_aligned : assert property (@(posedge clk) disable iff (!rst_n)
                                    word_valid_i |-> word_addr_i[1:0] == 2'b00);

endmodule
